colour_lookup_arbiter: RTL and testbench
========================================

# colour_lookup_arbiter

Shares the single colour-converter block-RAM lookup (8 entries, 3-bit colour address, 24-bit RGB data, registered read) between two independent requesters. Each requester presents a colour code with a req/done handshake and receives the 24-bit RGB word in its own output register. The block sits directly in front of the colour-converter memory: it owns the memory's enable and address and is the only agent that drives them.

## Interface
- READ_LATENCY, 1: clock edges from the edge that samples `rom_en`/`rom_addr` to the edge where `rom_rgb` is valid for capture. Legal values are 1–4.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_0  in  1  requester 0 request; held high until `done_0`.
- colour_0  in  3  requester 0 colour code; must be stable while `req_0` is high.
- req_1  in  1  requester 1 request.
- colour_1  in  3  requester 1 colour code.
- done_0  out  1  one-cycle pulse: `rgb_0` has been updated.
- rgb_0  out  24  last RGB result for requester 0; held between transactions.
- done_1  out  1  one-cycle pulse for requester 1.
- rgb_1  out  24  last RGB result for requester 1.
- busy  out  1  high in every state except IDLE.
- rom_en  out  1  memory enable.
- rom_we  out  1  memory write enable; constant 0.
- rom_addr  out  3  memory address.
- rom_rgb  in  24  memory read data.

## Operation
- The FSM has four states: IDLE, READ, WAIT and DONE.
- **Grant registers:** the FSM holds the grant in `owner_q` (1 bit) and the captured address in `addr_q` (3 bits). It records the last-granted requester in `last_q` (1 bit).
- **IDLE:** if any `req_k` is high, pick a winner.
  - With a single request, that requester wins.
  - With both requesting, the requester with index != `last_q` wins (round-robin).
  - On a grant: `owner_q` ← winner, `addr_q` ← `colour_winner`, `last_q` ← winner, and the FSM moves to READ.
  - With no request, the FSM stays in IDLE.
- **READ:** lasts exactly 1 cycle, then moves to WAIT. The wait counter is loaded with READ_LATENCY−1.
- **WAIT:** lasts READ_LATENCY cycles. On the last WAIT edge (counter == 0), `rgb_owner` ← `rom_rgb`, and the FSM moves to DONE.
- **DONE:** lasts 1 cycle, then returns to IDLE.
- **Requests are sampled only in IDLE.**
  - `req_k` and `colour_k` are ignored in READ, WAIT and DONE.
  - Changes to `colour_k` after the grant do not affect the transaction in flight.
  - If `req_owner` drops mid-transaction, the transaction still completes and `done` still pulses.
- **Requester obligation:** drop `req_k` in the cycle after `done_k`. If `req_k` is still high when IDLE is re-entered, it is a new request.
- **Outputs per state:**
  - `rom_en` = 1 only in READ.
  - `rom_addr` = `addr_q` at all times.
  - `done_k` = 1 only in DONE with `owner_q` == k.
  - `busy` = (state != IDLE).
- **Non-owner output:** `rgb_k` of the non-owner never changes.
- **Reset values:**
  - State = IDLE, `last_q` = 1 (requester 0 wins the first tie).
  - `owner_q` = 0, `addr_q` = 0, counter = 0.
  - `rgb_0` = `rgb_1` = 24'h000000.
  - `done_0` = `done_1` = 0, `busy` = 0, `rom_en` = 0.
- **Reset mid-transaction:** the transaction is abandoned. No `done` pulses, and `rgb` outputs return to 0. A requester still holding `req` is re-serviced from IDLE.

## Timing
- **Latency:** with `req_k` high and the FSM in IDLE at edge t:
  - READ is cycle t+1.
  - WAIT covers cycles t+2 .. t+1+READ_LATENCY.
  - `done_k` is high in cycle t+2+READ_LATENCY.
  - With READ_LATENCY = 1, `done` comes 3 cycles after the request is sampled.
- **Data timing:** `rgb_k` is valid from the `done_k` cycle onward.
- **Throughput:** one lookup per 3+READ_LATENCY cycles.
- **Contention:** back-to-back contention alternates grants. Neither requester waits more than one transaction.

## Test plan
- Behavioural ROM model with READ_LATENCY = 1 and contents:
  - 0→000000, 1→0000FF, 2→00FF00, 3→00FFFF
  - 4→FF0000, 5→FF00FF, 6→FFFF00, 7→FFFFFF
- **Single request:** `req_0` with `colour_0` = 4 → `rom_en` high for 1 cycle with `rom_addr` = 4; `done_0` 3 cycles later; `rgb_0` = FF0000; `rgb_1` stays 000000.
- **Simultaneous requests from reset:** `req_0` (`colour_0` = 1) and `req_1` (`colour_1` = 6) held high → `done_0` first with `rgb_0` = 0000FF; then `done_1` 4 cycles later with `rgb_1` = FFFF00.
- **Persistent contention:** both requesters hold `req` for 4 transactions → grants alternate 0, 1, 0, 1; done pulses are spaced 4 cycles apart.
- **Colour change in flight:** `colour_0` changes from 2 to 7 in the READ cycle → `rgb_0` = 00FF00.
- **Reset during WAIT:** reset asserted during WAIT → no `done` pulse; `rgb` outputs = 0, `busy` = 0. With `req_1` held high and `colour_1` = 3, `done_1` follows 3 cycles after reset release with `rgb_1` = 00FFFF.
- **Longer latency:** rerun the single-request case with READ_LATENCY = 3 → `done_0` 5 cycles after the request is sampled; `rgb_0` correct for all 8 colours.

Source files
------------

// File: rtl/colour_lookup_arbiter.sv
// rtl/colour_lookup_arbiter.sv - round-robin arbiter sharing one registered-read colour lookup ROM
// between two requesters, each with its own held RGB result register.
module colour_lookup_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0,
  input  logic [2:0]  colour_0,
  input  logic        req_1,
  input  logic [2:0]  colour_1,
  output logic        done_0,
  output logic [23:0] rgb_0,
  output logic        done_1,
  output logic [23:0] rgb_1,
  output logic        busy,
  output logic        rom_en,
  output logic        rom_we,
  output logic [2:0]  rom_addr,
  input  logic [23:0] rom_rgb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  addr_q,  addr_d;
  logic        last_q,  last_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] rgb0_q,  rgb0_d;
  logic [23:0] rgb1_q,  rgb1_d;
  logic        win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= 3'd0;
      last_q  <= 1'b1;
      cnt_q   <= 2'd0;
      rgb0_q  <= 24'h000000;
      rgb1_q  <= 24'h000000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    win     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_0 || req_1) begin
          // On a tie the requester not served last wins.
          win     = (req_0 && req_1) ? ~last_q : req_1;
          owner_d = win;
          addr_d  = win ? colour_1 : colour_0;
          last_d  = win;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q) rgb1_d = rom_rgb;
          else         rgb0_d = rom_rgb;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_en   = (state_q == S_READ);
  assign rom_we   = 1'b0;
  assign rom_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done_0   = (state_q == S_DONE) && !owner_q;
  assign done_1   = (state_q == S_DONE) &&  owner_q;
  assign rgb_0    = rgb0_q;
  assign rgb_1    = rgb1_q;

endmodule

// File: tb/tb_colour_lookup_arbiter.sv
// tb/tb_colour_lookup_arbiter.sv - directed bench for colour_lookup_arbiter at read latency 1 and 3.
module tb_colour_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1;
  logic [2:0]  colour_0, colour_1;

  logic        a_done_0, a_done_1, a_busy, a_rom_en, a_rom_we;
  logic [23:0] a_rgb_0, a_rgb_1, a_rom_rgb;
  logic [2:0]  a_rom_addr;

  logic        b_done_0, b_done_1, b_busy, b_rom_en, b_rom_we;
  logic [23:0] b_rgb_0, b_rgb_1;
  logic [2:0]  b_rom_addr;
  logic [23:0] b_pipe [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  colour_lookup_arbiter #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_0(req_0), .colour_0(colour_0), .req_1(req_1), .colour_1(colour_1),
    .done_0(a_done_0), .rgb_0(a_rgb_0), .done_1(a_done_1), .rgb_1(a_rgb_1),
    .busy(a_busy), .rom_en(a_rom_en), .rom_we(a_rom_we), .rom_addr(a_rom_addr),
    .rom_rgb(a_rom_rgb)
  );

  colour_lookup_arbiter #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_0(req_0), .colour_0(colour_0), .req_1(req_1), .colour_1(colour_1),
    .done_0(b_done_0), .rgb_0(b_rgb_0), .done_1(b_done_1), .rgb_1(b_rgb_1),
    .busy(b_busy), .rom_en(b_rom_en), .rom_we(b_rom_we), .rom_addr(b_rom_addr),
    .rom_rgb(b_pipe[2])
  );

  function automatic logic [23:0] colour_rgb(input logic [2:0] c);
    case (c)
      3'd0: return 24'h000000;
      3'd1: return 24'h0000FF;
      3'd2: return 24'h00FF00;
      3'd3: return 24'h00FFFF;
      3'd4: return 24'hFF0000;
      3'd5: return 24'hFF00FF;
      3'd6: return 24'hFFFF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (a_rom_en) a_rom_rgb <= colour_rgb(a_rom_addr);
  end

  always @(posedge clk) begin
    if (b_rom_en) b_pipe[0] <= colour_rgb(b_rom_addr);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; colour_0 = 3'd0; colour_1 = 3'd0;
    step(2);
    chk("rst_busy",   32'(a_busy),   32'd0);
    chk("rst_rom_en", 32'(a_rom_en), 32'd0);
    chk("rst_rom_we", 32'(a_rom_we), 32'd0);
    chk("rst_done",   32'({a_done_0, a_done_1}), 32'd0);
    chk("rst_rgb0",   32'(a_rgb_0),  32'h0);
    chk("rst_rgb1",   32'(a_rgb_1),  32'h0);
    rst = 1'b0;
    step(1);

    // Single request, colour 4.
    req_0 = 1'b1; colour_0 = 3'd4;
    step(1);
    chk("s_read_en",   32'(a_rom_en),   32'd1);
    chk("s_read_addr", 32'(a_rom_addr), 32'd4);
    chk("s_read_busy", 32'(a_busy),     32'd1);
    step(1);
    chk("s_wait_en",   32'(a_rom_en),   32'd0);
    chk("s_wait_done", 32'(a_done_0),   32'd0);
    step(1);
    chk("s_done0",     32'(a_done_0),   32'd1);
    chk("s_done1",     32'(a_done_1),   32'd0);
    chk("s_rgb0",      32'(a_rgb_0),    32'hFF0000);
    chk("s_rgb1",      32'(a_rgb_1),    32'h000000);
    req_0 = 1'b0;
    step(1);
    chk("s_idle_done", 32'(a_done_0),   32'd0);
    chk("s_idle_busy", 32'(a_busy),     32'd0);
    chk("s_hold_rgb0", 32'(a_rgb_0),    32'hFF0000);

    // Simultaneous requests from reset: requester 0 wins the first tie.
    rst = 1'b1; step(1); rst = 1'b0;
    req_0 = 1'b1; colour_0 = 3'd1; req_1 = 1'b1; colour_1 = 3'd6;
    step(3);
    chk("t_done0",     32'(a_done_0),   32'd1);
    chk("t_rgb0",      32'(a_rgb_0),    32'h0000FF);
    chk("t_rgb1_hold", 32'(a_rgb_1),    32'h000000);
    req_0 = 1'b0;
    step(2);
    chk("t_read1_addr", 32'(a_rom_addr), 32'd6);
    step(2);
    chk("t_done1",     32'(a_done_1),   32'd1);
    chk("t_done1_0",   32'(a_done_0),   32'd0);
    chk("t_rgb1",      32'(a_rgb_1),    32'hFFFF00);
    req_1 = 1'b0;
    step(1);

    // Persistent contention: grants alternate 0,1,0,1 with done spaced 4 cycles.
    rst = 1'b1; step(1); rst = 1'b0;
    req_0 = 1'b1; colour_0 = 3'd3; req_1 = 1'b1; colour_1 = 3'd5;
    step(3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c%0d_done0", k), 32'(a_done_0), 32'((k % 2) == 0));
      chk($sformatf("c%0d_done1", k), 32'(a_done_1), 32'((k % 2) == 1));
      if ((k % 2) == 0) chk($sformatf("c%0d_rgb0", k), 32'(a_rgb_0), 32'h00FFFF);
      else              chk($sformatf("c%0d_rgb1", k), 32'(a_rgb_1), 32'hFF00FF);
      if (k < 3) begin
        step(2);
        chk($sformatf("c%0d_gap_done", k), 32'({a_done_0, a_done_1}), 32'd0);
        step(2);
      end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    step(1);

    // Colour change during READ must not affect the lookup.
    req_0 = 1'b1; colour_0 = 3'd2;
    step(1);
    colour_0 = 3'd7;
    step(2);
    chk("f_done0", 32'(a_done_0), 32'd1);
    chk("f_rgb0",  32'(a_rgb_0),  32'h00FF00);
    req_0 = 1'b0;
    step(1);

    // Reset during WAIT abandons the transaction; held request is re-serviced.
    req_1 = 1'b1; colour_1 = 3'd3;
    step(2);
    chk("r_in_wait", 32'(a_busy), 32'd1);
    rst = 1'b1;
    step(1);
    chk("r_busy", 32'(a_busy), 32'd0);
    chk("r_done", 32'({a_done_0, a_done_1}), 32'd0);
    chk("r_rgb0", 32'(a_rgb_0), 32'h0);
    chk("r_rgb1", 32'(a_rgb_1), 32'h0);
    rst = 1'b0;
    step(2);
    chk("r_pre_done1", 32'(a_done_1), 32'd0);
    step(1);
    chk("r_done1", 32'(a_done_1), 32'd1);
    chk("r_rgb1b", 32'(a_rgb_1),  32'h00FFFF);
    req_1 = 1'b0;
    step(1);

    // Read latency 3: done five cycles after the request is sampled, all colours.
    rst = 1'b1; step(1); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_0 = 1'b1; colour_0 = 3'(c);
      step(1);
      chk($sformatf("l3_%0d_en", c),   32'(b_rom_en),   32'd1);
      chk($sformatf("l3_%0d_addr", c), 32'(b_rom_addr), 32'(c));
      step(3);
      chk($sformatf("l3_%0d_early", c), 32'(b_done_0), 32'd0);
      step(1);
      chk($sformatf("l3_%0d_done", c), 32'(b_done_0), 32'd1);
      chk($sformatf("l3_%0d_rgb", c),  32'(b_rgb_0),  32'(colour_rgb(3'(c))));
      req_0 = 1'b0;
      step(1);
    end
    chk("l3_rgb1_hold", 32'(b_rgb_1), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
